lcd_bus_driver: RTL
===================

// Module: lcd_bus_driver
// PURPOSE
//  Responder end of the character-LCD host handshake (iDATA/iRS/iStart/oDone).
//  Takes one byte per request from a sequencer and generates HD44780 bus cycles:
//  RS/RW/DATA setup, timed EN pulse, hold, then command-execution wait.
//  Sits between the LCD text/init sequencer and the LCD_* board pins.
// PARAMETERS
//  T_SETUP   4      cycles RS/RW/DATA stable before EN rises
//  T_EN      16     cycles EN held high
//  T_HOLD    4      cycles DATA/RS held after EN falls
//  T_EXEC    2000   post-write wait, normal command/data (~40us @50MHz)
//  T_LONG    82000  post-write wait, clear/home (RS=0, data 8'h01..8'h03)
//  POLL_MAX  4096   max busy-flag reads before timeout (LCD_BUSY_POLL_EN only)
// PORTS
//  iCLK      in   1  system clock
//  iRST_N    in   1  async active-low reset
//  iDATA     in   8  byte to write, latched at accept
//  iRS       in   1  register select (0 cmd, 1 data), latched at accept
//  iStart    in   1  request level; accepted on 0->1 transition only
//  oDone     out  1  one-cycle pulse, transfer and wait complete
//  oBusy     out  1  high from accept until the oDone cycle inclusive
//  oErr      out  1  one-cycle pulse with oDone on busy-poll timeout
//  LCD_DATA  inout 8 LCD data bus
//  LCD_RW    out  1  0 write, 1 read
//  LCD_EN    out  1  enable strobe
//  LCD_RS    out  1  register select to panel
// BEHAVIOUR
//  - Reset (async, immediate, also mid-transfer): state IDLE, counters 0,
//    oDone=0, oBusy=0, oErr=0, LCD_EN=0, LCD_RW=0, LCD_RS=0, LCD_DATA driven 8'h00.
//  - iStart registered each cycle; accept when iStart=1 & prev=0 & state IDLE.
//    Edges outside IDLE are ignored, never queued; iStart held high after
//    oDone does not retrigger. Accept edge = cycle k.
//  - States: IDLE -> SETUP(T_SETUP) -> ENABLE(T_EN) -> HOLD(T_HOLD) -> EXEC -> DONE -> IDLE.
//  - SETUP..HOLD: LCD_RS=latched RS, LCD_RW=0, LCD_DATA=latched byte; LCD_EN=1
//    only in ENABLE. After HOLD, LCD_DATA/LCD_RS keep last value (no glitch).
//  - EXEC waits T_LONG if latched RS=0 and byte in {8'h01,8'h02,8'h03}, else T_EXEC.
//  - DONE: oDone=1 for exactly one cycle, at cycle k+1+T_SETUP+T_EN+T_HOLD+wait.
//  - Single down-counter, width $clog2 of max(T_LONG, POLL_MAX*(T_SETUP+T_EN+T_HOLD))+1.
//  - Back-to-back: new edge accepted earliest the cycle after DONE.
// CONFIGURATION
//  LCD_BUSY_POLL_EN defined: EXEC replaced by busy-flag poll loop:
//   LCD_RS=0, LCD_RW=1, LCD_DATA released (Z); T_SETUP, EN high T_EN, sample
//   LCD_DATA[7] on last EN-high cycle, EN low T_HOLD. BF=1 -> repeat; BF=0 ->
//   DONE. After POLL_MAX reads with BF=1 -> DONE with oErr=1. LCD_RW returns 0
//   and bus re-driven in DONE.
//  Not defined: fixed EXEC wait as above; LCD_RW constant 0, bus never Z,
//   oErr tied 0.
// TESTING  (T_SETUP=2,T_EN=4,T_HOLD=2,T_EXEC=10,T_LONG=50,POLL_MAX=3)
//  1 iRS=1,iDATA=8'h44, iStart rise at k -> EN high k+3..k+6, LCD_RS=1,
//    LCD_DATA=8'h44 k+1..k+8, oDone single pulse at k+19, oBusy k+1..k+19.
//  2 iRS=0,iDATA=8'h01 -> oDone at k+59; iRS=0,8'h38 -> oDone at k+19.
//  3 iStart held high 100 cycles after oDone -> exactly one transfer; second
//    rise during EXEC -> ignored, no extra EN pulse.
//  4 iRST_N low at k+5 (EN high) -> LCD_EN=0, oBusy=0 same cycle; after
//    release, fresh iStart rise -> full normal transfer.
//  5 (LCD_BUSY_POLL_EN) model BF=1 for 2 reads then 0 -> 3 read EN pulses,
//    LCD_RW=1, bus Z during poll, oDone no oErr; BF stuck 1 -> oDone+oErr
//    after 3 reads.
//  6 Change iDATA to 8'hFF at k+2 -> LCD_DATA stays 8'h44 through HOLD.

Source files
------------

// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver: turns one start/done request into an HD44780 write cycle followed by an execute wait.
// Build option LCD_BUSY_POLL_EN: the fixed execute wait is replaced by busy-flag read polling.
module lcd_bus_driver #(
  parameter int T_SETUP  = 4,
  parameter int T_EN     = 16,
  parameter int T_HOLD   = 4,
  parameter int T_EXEC   = 2000,
  parameter int T_LONG   = 82000,
  parameter int POLL_MAX = 4096
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] iDATA,
  input  logic       iRS,
  input  logic       iStart,
  output logic       oDone,
  output logic       oBusy,
  output logic       oErr,
  inout  wire  [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  // state  | meaning
  // IDLE   | waiting for a 0->1 edge on iStart
  // SETUP  | RS/RW/DATA driven, EN low
  // ENABLE | EN high (write strobe)
  // HOLD   | EN low, DATA/RS held
  // EXEC   | fixed command-execution wait
  // PSETUP | busy-flag read: RW=1, bus released, EN low
  // PEN    | busy-flag read: EN high, BF sampled on last cycle
  // PHOLD  | busy-flag read: EN low, decide repeat/done
  // DONE   | oDone pulse, bus re-driven with the written byte
  typedef enum logic [3:0] {
    IDLE, SETUP, ENABLE, HOLD, EXEC, PSETUP, PEN, PHOLD, DONE
  } state_t;

  localparam int CYC_LEN   = T_SETUP + T_EN + T_HOLD;
  localparam int POLL_SPAN = POLL_MAX * CYC_LEN;
  localparam int CNT_MAX   = (T_LONG > POLL_SPAN) ? T_LONG : POLL_SPAN;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  state_t           state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             tc;
  logic             accept;
  logic             prevStart;
  logic             rsLat;
  logic [7:0]       dataLat;
  logic             longWait;

  assign tc       = (cnt == '0);
  // clear display / return home need the long execution time
  assign longWait = !rsLat && (dataLat >= 8'h01) && (dataLat <= 8'h03);

`ifdef LCD_BUSY_POLL_EN
  localparam int RC_W = $clog2(POLL_MAX + 1);
  logic [RC_W-1:0] readCnt;
  logic            bfLat;
  logic            errLat;
  logic            inPoll;
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = tc ? cnt : cnt - CNT_W'(1);
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (iStart && !prevStart) begin
          accept    = 1'b1;
          stateNext = SETUP;
          cntNext   = CNT_W'(T_SETUP - 1);
        end
      end
      SETUP: begin
        if (tc) begin
          stateNext = ENABLE;
          cntNext   = CNT_W'(T_EN - 1);
        end
      end
      ENABLE: begin
        if (tc) begin
          stateNext = HOLD;
          cntNext   = CNT_W'(T_HOLD - 1);
        end
      end
      HOLD: begin
        if (tc) begin
`ifdef LCD_BUSY_POLL_EN
          stateNext = PSETUP;
          cntNext   = CNT_W'(T_SETUP - 1);
`else
          stateNext = EXEC;
          cntNext   = longWait ? CNT_W'(T_LONG - 1) : CNT_W'(T_EXEC - 1);
`endif
        end
      end
      EXEC: begin
        if (tc) stateNext = DONE;
      end
`ifdef LCD_BUSY_POLL_EN
      PSETUP: begin
        if (tc) begin
          stateNext = PEN;
          cntNext   = CNT_W'(T_EN - 1);
        end
      end
      PEN: begin
        if (tc) begin
          stateNext = PHOLD;
          cntNext   = CNT_W'(T_HOLD - 1);
        end
      end
      PHOLD: begin
        if (tc) begin
          if (!bfLat || readCnt == RC_W'(POLL_MAX - 1)) begin
            stateNext = DONE;
          end else begin
            stateNext = PSETUP;
            cntNext   = CNT_W'(T_SETUP - 1);
          end
        end
      end
`endif
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      prevStart <= 1'b0;
      rsLat     <= 1'b0;
      dataLat   <= 8'h00;
    end else begin
      prevStart <= iStart;
      if (accept) begin
        rsLat   <= iRS;
        dataLat <= iDATA;
      end
    end
  end

`ifdef LCD_BUSY_POLL_EN
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      readCnt <= '0;
      bfLat   <= 1'b0;
      errLat  <= 1'b0;
    end else begin
      if (state == HOLD && tc) begin
        readCnt <= '0;
        errLat  <= 1'b0;
      end
      if (state == PEN && tc) bfLat <= LCD_DATA[7];
      if (state == PHOLD && tc && bfLat) begin
        if (readCnt == RC_W'(POLL_MAX - 1)) errLat <= 1'b1;
        else readCnt <= readCnt + RC_W'(1);
      end
    end
  end

  assign inPoll   = (state == PSETUP) || (state == PEN) || (state == PHOLD);
  assign LCD_EN   = (state == ENABLE) || (state == PEN);
  assign LCD_RW   = inPoll;
  assign LCD_RS   = inPoll ? 1'b0 : rsLat;
  assign LCD_DATA = inPoll ? 8'hzz : dataLat;
  assign oErr     = (state == DONE) && errLat;
`else
  assign LCD_EN   = (state == ENABLE);
  assign LCD_RW   = 1'b0;
  assign LCD_RS   = rsLat;
  assign LCD_DATA = dataLat;
  assign oErr     = 1'b0;
`endif

  assign oBusy = (state != IDLE);
  assign oDone = (state == DONE);

endmodule
